// File: rtl/jtag_dma_sequencer.sv
// jtag_dma_sequencer: system-clock-side executor of the DMA commands issued
// by the JTAG chain-1 logic. Moves 32-bit words between the system half of
// the ping-pong buffer and the shared bus, splitting each block into bursts
// of at most burst_size+1 beats and re-arbitrating the bus for every burst.
module jtag_dma_sequencer (
    input  logic        system_clk,
    input  logic        n_reset,
    input  logic        launch_write,
    input  logic        launch_read,
    input  logic        launch_simple_switch,
    input  logic [31:0] start_address,
    input  logic [3:0]  byte_enable,
    input  logic [7:0]  burst_size,
    input  logic [7:0]  block_size,
    output logic        busy,
    output logic        operation_done,
    output logic        error,
    output logic [7:0]  block_size_out,
    output logic [8:0]  buf_address,
    output logic        buf_write_enable,
    output logic [31:0] buf_data_in,
    input  logic [31:0] buf_data_out,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic        begin_transaction,
    output logic [31:0] bus_address,
    output logic [7:0]  bus_burst_size,
    output logic        bus_read_n_write,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_data_out,
    output logic        bus_data_valid_out,
    input  logic [31:0] bus_data_in,
    input  logic        bus_data_valid_in,
    input  logic        bus_busy,
    output logic        end_transaction,
    input  logic        bus_error
);

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_REQUEST        = 3'd1;
    localparam logic [2:0] S_BEGIN          = 3'd2;
    localparam logic [2:0] S_WRITE_PREFETCH = 3'd3;
    localparam logic [2:0] S_WRITE_BEAT     = 3'd4;
    localparam logic [2:0] S_READ_BEAT      = 3'd5;
    localparam logic [2:0] S_END_BURST      = 3'd6;
    localparam logic [2:0] S_FINISH         = 3'd7;

    logic [2:0]  state;
    logic        is_write;
    logic [31:0] addr;        // word-aligned start of the next burst
    logic [3:0]  be;
    logic [7:0]  bsz;         // latched burst_size (beats-1 cap)
    logic [7:0]  remaining;   // words still to move
    logic [7:0]  beats;       // beats in the current burst
    logic [7:0]  beat_cnt;    // beats completed in the current burst
    logic [7:0]  index;       // buffer word index, runs across bursts

    logic [8:0]  burst_cap;
    logic [7:0]  beats_calc;
    logic        bus_state;
    logic        wr_step;
    logic        rd_step;
    logic        last_beat;

    // burst_cap is 9 bits so burst_size=255 (256 beats) still compares correctly
    assign burst_cap  = {1'b0, bsz} + 9'd1;
    assign beats_calc = (burst_cap < {1'b0, remaining}) ? burst_cap[7:0] : remaining;

    assign bus_state = (state == S_REQUEST) || (state == S_BEGIN) ||
                       (state == S_WRITE_PREFETCH) || (state == S_WRITE_BEAT) ||
                       (state == S_READ_BEAT);
    assign wr_step   = (state == S_WRITE_BEAT) && !bus_busy && !bus_error;
    assign rd_step   = (state == S_READ_BEAT) && bus_data_valid_in && !bus_error;
    assign last_beat = (beat_cnt == beats - 8'd1);

    // Request is held from arbitration through the last beat; dropped in END_BURST
    assign bus_request       = bus_state;
    assign begin_transaction = (state == S_BEGIN);
    assign bus_address       = begin_transaction ? addr : 32'd0;
    assign bus_burst_size    = begin_transaction ? (beats_calc - 8'd1) : 8'd0;
    assign bus_read_n_write  = begin_transaction && !is_write;
    assign bus_byte_enable   = be;
    assign bus_data_valid_out = (state == S_WRITE_BEAT);
    assign bus_data_out      = bus_data_valid_out ? buf_data_out : 32'd0;
    assign end_transaction   = (state == S_END_BURST);
    assign buf_write_enable  = rd_step;
    assign buf_data_in       = rd_step ? bus_data_in : 32'd0;

    // Buffer address; during write beats it looks one word ahead whenever the
    // current beat completes so the synchronous read keeps beats gap-free
    always_comb begin
        buf_address = 9'd0;
        case (state)
            S_WRITE_PREFETCH: buf_address = {1'b0, index};
            S_WRITE_BEAT:     buf_address = {1'b0, bus_busy ? index : index + 8'd1};
            S_READ_BEAT:      buf_address = {1'b0, index};
            default:          buf_address = 9'd0;
        endcase
    end

    // Sequencer state, transfer bookkeeping and sticky status
    always_ff @(posedge system_clk) begin
        if (!n_reset) begin
            state          <= S_IDLE;
            is_write       <= 1'b0;
            addr           <= 32'd0;
            be             <= 4'd0;
            bsz            <= 8'd0;
            remaining      <= 8'd0;
            beats          <= 8'd0;
            beat_cnt       <= 8'd0;
            index          <= 8'd0;
            busy           <= 1'b0;
            operation_done <= 1'b0;
            error          <= 1'b0;
            block_size_out <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_write || launch_read || launch_simple_switch) begin
                        is_write       <= launch_write;
                        addr           <= start_address & 32'hFFFF_FFFC;
                        be             <= byte_enable;
                        bsz            <= burst_size;
                        remaining      <= block_size;
                        index          <= 8'd0;
                        busy           <= 1'b1;
                        operation_done <= 1'b0;
                        error          <= 1'b0;
                        if (launch_write) begin
                            block_size_out <= block_size;
                            state <= (block_size == 8'd0) ? S_FINISH : S_REQUEST;
                        end else if (launch_read) begin
                            block_size_out <= 8'd0;
                            state <= (block_size == 8'd0) ? S_FINISH : S_REQUEST;
                        end else begin
                            block_size_out <= block_size;
                            state <= S_FINISH;
                        end
                    end
                end
                S_REQUEST: if (bus_grant) state <= S_BEGIN;
                S_BEGIN: begin
                    beats    <= beats_calc;
                    beat_cnt <= 8'd0;
                    state    <= is_write ? S_WRITE_PREFETCH : S_READ_BEAT;
                end
                S_WRITE_PREFETCH: state <= S_WRITE_BEAT;
                S_WRITE_BEAT: begin
                    if (wr_step) begin
                        index    <= index + 8'd1;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) state <= S_END_BURST;
                    end
                end
                S_READ_BEAT: begin
                    if (rd_step) begin
                        index          <= index + 8'd1;
                        block_size_out <= block_size_out + 8'd1;
                        beat_cnt       <= beat_cnt + 8'd1;
                        if (last_beat) state <= S_END_BURST;
                    end
                end
                S_END_BURST: begin
                    addr      <= addr + {22'd0, beats, 2'b00};
                    remaining <= remaining - beats;
                    state     <= (error || remaining == beats) ? S_FINISH : S_REQUEST;
                end
                S_FINISH: begin
                    if (is_write) block_size_out <= 8'd0;
                    busy           <= 1'b0;
                    operation_done <= 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A slave error aborts the burst: close it and finish the operation
            if (bus_state && bus_error) begin
                error <= 1'b1;
                state <= S_END_BURST;
            end
        end
    end

endmodule

// File: tb/tb_jtag_dma_sequencer.sv
// Bench for jtag_dma_sequencer: a bus-slave/buffer agent drives the bus while
// scoreboard queues hold the expected bursts, write beats and buffer writes.
module tb_jtag_dma_sequencer;

    logic        system_clk = 1'b0;
    logic        n_reset;
    logic        launch_write, launch_read, launch_simple_switch;
    logic [31:0] start_address;
    logic [3:0]  byte_enable;
    logic [7:0]  burst_size, block_size;
    logic        busy, operation_done, error;
    logic [7:0]  block_size_out;
    logic [8:0]  buf_address;
    logic        buf_write_enable;
    logic [31:0] buf_data_in, buf_data_out;
    logic        bus_request, bus_grant, begin_transaction;
    logic [31:0] bus_address;
    logic [7:0]  bus_burst_size;
    logic        bus_read_n_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_data_out, bus_data_in;
    logic        bus_data_valid_out, bus_data_valid_in, bus_busy;
    logic        end_transaction, bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt = 32'h0;

    logic [40:0] exp_bu[$];   // {bus_address, bus_burst_size, bus_read_n_write}
    logic [35:0] exp_wd[$];   // {bus_data_out, bus_byte_enable}
    logic [40:0] exp_bw[$];   // {buf_address, buf_data_in}

    logic [133:0] all_outs;
    assign all_outs = {busy, operation_done, error, block_size_out, buf_address,
                       buf_write_enable, buf_data_in, bus_request, begin_transaction,
                       bus_address, bus_burst_size, bus_read_n_write, bus_byte_enable,
                       bus_data_out, bus_data_valid_out, end_transaction};

    jtag_dma_sequencer dut (
        .system_clk(system_clk), .n_reset(n_reset),
        .launch_write(launch_write), .launch_read(launch_read),
        .launch_simple_switch(launch_simple_switch),
        .start_address(start_address), .byte_enable(byte_enable),
        .burst_size(burst_size), .block_size(block_size),
        .busy(busy), .operation_done(operation_done), .error(error),
        .block_size_out(block_size_out), .buf_address(buf_address),
        .buf_write_enable(buf_write_enable), .buf_data_in(buf_data_in),
        .buf_data_out(buf_data_out), .bus_request(bus_request), .bus_grant(bus_grant),
        .begin_transaction(begin_transaction), .bus_address(bus_address),
        .bus_burst_size(bus_burst_size), .bus_read_n_write(bus_read_n_write),
        .bus_byte_enable(bus_byte_enable), .bus_data_out(bus_data_out),
        .bus_data_valid_out(bus_data_valid_out), .bus_data_in(bus_data_in),
        .bus_data_valid_in(bus_data_valid_in), .bus_busy(bus_busy),
        .end_transaction(end_transaction), .bus_error(bus_error)
    );

    always #5 system_clk = ~system_clk;

    // Buffer contents are a salted hash of the word address
    function automatic logic [31:0] pat(input logic [8:0] a);
        return salt ^ ({23'd0, a} * 32'h9E3779B1);
    endfunction

    // Buffer read port with one cycle of latency
    always @(posedge system_clk) buf_data_out <= pat(buf_address);

    task automatic set_cfg(input logic [31:0] a, input logic [3:0] b,
                           input logic [7:0] bs, input logic [7:0] blk);
        start_address = a; byte_enable = b; burst_size = bs; block_size = blk;
    endtask

    task automatic clear_inputs();
        launch_write = 0; launch_read = 0; launch_simple_switch = 0;
        bus_grant = 0; bus_busy = 0; bus_error = 0;
        bus_data_valid_in = 0; bus_data_in = '0;
    endtask

    // Launch (lmask = {switch, read, write}) and act as bus slave until done
    task automatic run_op(input logic [2:0] lmask, input int gdel, input int stall_beat,
                          input int stall_len, input bit gaps, input int err_beat,
                          input int relaunch_at, output int n_begin, output int n_end,
                          output int n_wvalid, output int done_cyc, output int first_req,
                          output logic busy1);
        int req_wait, req_start, rd_left, rd_idx, wbeats, stall_cnt, beg_cyc;
        bit wfirst;
        logic [40:0] e41;
        logic [35:0] e36;
        n_begin = 0; n_end = 0; n_wvalid = 0; done_cyc = -1; first_req = -1; busy1 = 0;
        req_wait = 0; req_start = 0; rd_left = 0; rd_idx = 0; wbeats = 0;
        stall_cnt = 0; beg_cyc = 0; wfirst = 0;
        for (int it = 0; it < 300; it++) begin
            @(posedge system_clk); #1;
            launch_write         = (it == 0) && lmask[0];
            launch_read          = ((it == 0) && lmask[1]) || (it == relaunch_at);
            launch_simple_switch = (it == 0) && lmask[2];
            if (bus_request) begin
                if (req_wait == 0) begin
                    req_start = it;
                    if (first_req < 0) first_req = it;
                end
                req_wait++;
            end else req_wait = 0;
            bus_grant = bus_request && (req_wait > gdel);
            bus_busy = bus_data_valid_out && (wbeats == stall_beat) && (stall_cnt < stall_len);
            if (bus_busy) stall_cnt++;
            bus_data_valid_in = 0; bus_error = 0; bus_data_in = '0;
            if (rd_left > 0) begin
                if (rd_idx == err_beat) begin
                    bus_error = 1; rd_left = 0;
                end else if (!gaps || $urandom_range(0, 1) == 1) begin
                    bus_data_valid_in = 1;
                    bus_data_in = $urandom;
                    exp_bw.push_back({9'(rd_idx), bus_data_in});
                    rd_idx++; rd_left--;
                end
            end

            @(negedge system_clk);
            if (it == 1) busy1 = busy;
            if (begin_transaction) begin
                n_begin++;
                checks++;
                if (exp_bu.size() == 0) begin
                    errors++;
                    $display("FAIL burst: unexpected begin addr=%h size=%0d", bus_address, bus_burst_size);
                end else begin
                    e41 = exp_bu.pop_front();
                    if ({bus_address, bus_burst_size, bus_read_n_write} !== e41) begin
                        errors++;
                        $display("FAIL burst: got addr=%h size=%0d rnw=%b, want addr=%h size=%0d rnw=%b",
                                 bus_address, bus_burst_size, bus_read_n_write, e41[40:9], e41[8:1], e41[0]);
                    end
                end
                checks++;
                if (it - req_start !== gdel + 1) begin
                    errors++;
                    $display("FAIL grant_latency: got %0d cycles, want %0d", it - req_start, gdel + 1);
                end
                if (bus_read_n_write) rd_left = int'(bus_burst_size) + 1;
                else begin beg_cyc = it; wfirst = 1; end
            end
            if (bus_data_valid_out) begin
                n_wvalid++;
                if (wfirst) begin
                    wfirst = 0;
                    checks++;
                    if (it - beg_cyc !== 2) begin
                        errors++;
                        $display("FAIL write_latency: got %0d, want 2", it - beg_cyc);
                    end
                end
                checks++;
                if (exp_wd.size() == 0) begin
                    errors++;
                    $display("FAIL wbeat: unexpected beat data=%h", bus_data_out);
                end else begin
                    if ({bus_data_out, bus_byte_enable} !== exp_wd[0]) begin
                        errors++;
                        $display("FAIL wbeat %0d: got data=%h be=%b, want data=%h be=%b",
                                 wbeats, bus_data_out, bus_byte_enable, exp_wd[0][35:4], exp_wd[0][3:0]);
                    end
                    if (!bus_busy) begin e36 = exp_wd.pop_front(); wbeats++; end
                end
            end
            if (buf_write_enable) begin
                checks++;
                if (exp_bw.size() == 0) begin
                    errors++;
                    $display("FAIL bufwr: unexpected write addr=%0d", buf_address);
                end else begin
                    e41 = exp_bw.pop_front();
                    if ({buf_address, buf_data_in} !== e41) begin
                        errors++;
                        $display("FAIL bufwr: got addr=%0d data=%h, want addr=%0d data=%h",
                                 buf_address, buf_data_in, e41[40:32], e41[31:0]);
                    end
                end
            end
            if (end_transaction) n_end++;
            if (it >= 1 && operation_done === 1'b1 && busy === 1'b0) begin
                done_cyc = it;
                break;
            end
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL timeout: operation not done within 300 cycles");
        end
        checks++;
        if (exp_bu.size() + exp_wd.size() + exp_bw.size() != 0) begin
            errors++;
            $display("FAIL leftover: bursts=%0d wbeats=%0d bufwr=%0d still expected",
                     exp_bu.size(), exp_wd.size(), exp_bw.size());
        end
        exp_bu.delete(); exp_wd.delete(); exp_bw.delete();
        @(posedge system_clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        n_reset = 0;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs);
        end
        @(posedge system_clk); #1;
        n_reset = 1;
        repeat (2) @(negedge system_clk);
        checks++;
        if (busy !== 0 || bus_request !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b req=%b, want 0 0", busy, bus_request);
        end
    endtask

    task automatic test_switch();
        int nb, ne, nw, dc, fr;
        logic b1;
        set_cfg(32'h0, 4'h0, 8'd0, 8'd5);
        run_op(3'b100, 0, -1, 0, 0, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (dc !== 2 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL switch_timing: done_cycle=%0d busy1=%b, want 2 1", dc, b1);
        end
        checks++;
        if (nb != 0 || nw != 0 || fr != -1) begin
            errors++;
            $display("FAIL switch_bus: begins=%0d beats=%0d req=%0d, want none", nb, nw, fr);
        end
        checks++;
        if (block_size_out !== 8'd5 || operation_done !== 1'b1) begin
            errors++;
            $display("FAIL switch_status: bso=%0d done=%b, want 5 1", block_size_out, operation_done);
        end
    endtask

    task automatic test_zero_block();
        int nb, ne, nw, dc, fr;
        logic b1;
        set_cfg(32'h800, 4'hF, 8'd3, 8'd0);
        run_op(3'b001, 0, -1, 0, 0, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (dc !== 2 || nb != 0 || fr != -1 || block_size_out !== 8'd0) begin
            errors++;
            $display("FAIL zero_block: done_cycle=%0d begins=%0d req=%0d bso=%0d, want 2 0 -1 0",
                     dc, nb, fr, block_size_out);
        end
    endtask

    task automatic test_write_basic();
        int nb, ne, nw, dc, fr;
        logic b1;
        salt = 32'h1234_5678;
        set_cfg(32'h1000, 4'b1011, 8'd3, 8'd10);
        exp_bu.push_back({32'h1000, 8'd3, 1'b0});
        exp_bu.push_back({32'h1010, 8'd3, 1'b0});
        exp_bu.push_back({32'h1020, 8'd1, 1'b0});
        for (int i = 0; i < 10; i++) exp_wd.push_back({pat(9'(i)), 4'b1011});
        run_op(3'b001, 0, -1, 0, 0, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (nb != 3 || ne != 3 || nw != 10 || fr != 1) begin
            errors++;
            $display("FAIL write_counts: begins=%0d ends=%0d valid=%0d first_req=%0d, want 3 3 10 1",
                     nb, ne, nw, fr);
        end
        checks++;
        if (block_size_out !== 8'd0 || operation_done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL write_status: bso=%0d done=%b err=%b, want 0 1 0",
                     block_size_out, operation_done, error);
        end
    endtask

    task automatic test_read_gaps();
        int nb, ne, nw, dc, fr;
        logic b1;
        set_cfg(32'h2000, 4'hF, 8'd7, 8'd6);
        exp_bu.push_back({32'h2000, 8'd5, 1'b1});
        run_op(3'b010, 2, -1, 0, 1, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (nb != 1 || ne != 1 || block_size_out !== 8'd6 || operation_done !== 1'b1) begin
            errors++;
            $display("FAIL read_gaps: begins=%0d ends=%0d bso=%0d done=%b, want 1 1 6 1",
                     nb, ne, block_size_out, operation_done);
        end
    endtask

    task automatic test_write_stall();
        int nb, ne, nw, dc, fr;
        logic b1;
        salt = 32'hCAFE_0011;
        set_cfg(32'h3000, 4'b0110, 8'd3, 8'd6);
        exp_bu.push_back({32'h3000, 8'd3, 1'b0});
        exp_bu.push_back({32'h3010, 8'd1, 1'b0});
        for (int i = 0; i < 6; i++) exp_wd.push_back({pat(9'(i)), 4'b0110});
        run_op(3'b001, 5, 2, 3, 0, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (nw != 9 || nb != 2 || ne != 2) begin
            errors++;
            $display("FAIL write_stall: valid_cycles=%0d begins=%0d ends=%0d, want 9 2 2", nw, nb, ne);
        end
        checks++;
        if (block_size_out !== 8'd0 || operation_done !== 1'b1) begin
            errors++;
            $display("FAIL write_stall_status: bso=%0d done=%b, want 0 1", block_size_out, operation_done);
        end
    endtask

    task automatic test_read_error();
        int nb, ne, nw, dc, fr;
        logic b1;
        set_cfg(32'h7000, 4'hF, 8'd7, 8'd8);
        exp_bu.push_back({32'h7000, 8'd7, 1'b1});
        run_op(3'b010, 0, -1, 0, 0, 3, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (ne != 1 || error !== 1'b1 || operation_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_error: ends=%0d err=%b done=%b busy=%b, want 1 1 1 0",
                     ne, error, operation_done, busy);
        end
        checks++;
        if (block_size_out !== 8'd3) begin
            errors++;
            $display("FAIL read_error_bso: got %0d, want 3", block_size_out);
        end
    endtask

    task automatic test_back_to_back();
        int nb, ne, nw, dc, fr, stray;
        logic b1;
        salt = 32'h0BAD_F00D;
        set_cfg(32'h4002, 4'b1100, 8'd3, 8'd4);
        exp_bu.push_back({32'h4000, 8'd3, 1'b0});
        for (int i = 0; i < 4; i++) exp_wd.push_back({pat(9'(i)), 4'b1100});
        run_op(3'b011, 0, -1, 0, 0, -1, 3, nb, ne, nw, dc, fr, b1);
        checks++;
        if (nb != 1 || block_size_out !== 8'd0 || operation_done !== 1'b1) begin
            errors++;
            $display("FAIL priority: begins=%0d bso=%0d done=%b, want 1 0 1",
                     nb, block_size_out, operation_done);
        end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge system_clk);
            if (busy !== 1'b0 || bus_request !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL ignored_launch: %0d busy/request cycles after done, want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int nb, ne, nw, dc, fr;
        logic b1;
        bit hit;
        salt = 32'h5A5A_0000;
        set_cfg(32'h5000, 4'hF, 8'd7, 8'd8);
        hit = 0;
        for (int it = 0; it < 50 && !hit; it++) begin
            @(posedge system_clk); #1;
            launch_write = (it == 0);
            bus_grant = bus_request;
            @(negedge system_clk);
            if (bus_data_valid_out === 1'b1) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: no write beat within 50 cycles");
        end
        @(posedge system_clk); #1;
        n_reset = 0;
        @(posedge system_clk); #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs %h, want 0", all_outs);
        end
        clear_inputs();
        n_reset = 1;
        set_cfg(32'h6000, 4'hF, 8'd0, 8'd2);
        exp_bu.push_back({32'h6000, 8'd0, 1'b1});
        exp_bu.push_back({32'h6004, 8'd0, 1'b1});
        run_op(3'b010, 1, -1, 0, 0, -1, -1, nb, ne, nw, dc, fr, b1);
        checks++;
        if (nb != 2 || block_size_out !== 8'd2 || operation_done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_read: begins=%0d bso=%0d done=%b err=%b, want 2 2 1 0",
                     nb, block_size_out, operation_done, error);
        end
    endtask

    initial begin
        clear_inputs();
        n_reset = 0;
        set_cfg(32'h0, 4'h0, 8'd0, 8'd0);
        test_reset();
        test_switch();
        test_zero_block();
        test_write_basic();
        test_read_gaps();
        test_write_stall();
        test_read_error();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
